// File: rtl/dnn_result_collector.sv
// dnn_result_collector
// Captures each out0/out1 result pair from the DNN datapath on its ready
// pulse, computes the signed margin (out1 - out0) and class decision, and
// buffers the results in a small circular FIFO drained through a
// valid/ready handshake. Dropped results (FIFO full) and ready-pulse
// disagreements are accounted in sticky/saturating status registers.
module dnn_result_collector #(
  parameter int DEPTH = 4,
  parameter int DW    = 21,
  parameter int CW    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [DW-1:0]    out0,
  input  logic signed [DW-1:0]    out1,
  input  logic                    out0_ready,
  input  logic                    out1_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [DW-1:0]    res_out0,
  output logic signed [DW-1:0]    res_out1,
  output logic signed [DW:0]      res_margin,
  output logic                    res_class,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [CW-1:0]           drop_count,
  output logic                    overflow,
  output logic                    proto_err,
  input  logic                    clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  // Margin is formed one bit wider than the operands so it can never wrap.
  function automatic logic signed [DW:0] calc_margin(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    logic signed [DW:0] ext_a;
    logic signed [DW:0] ext_b;
    ext_a = {a[DW-1], a};
    ext_b = {b[DW-1], b};
    return ext_b - ext_a;
  endfunction

  // Class is 1 only for a strictly positive margin; a tie resolves to 0.
  function automatic logic calc_class(input logic signed [DW:0] m);
    return ~m[DW] & (|m);
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Capture stage registers (data unreset, valid reset)
  logic signed [DW-1:0] r_out0_p0;
  logic signed [DW-1:0] r_out1_p0;
  logic                 r_vld_p0;

  // FIFO storage and control
  logic signed [DW-1:0] r_mem_out0   [DEPTH];
  logic signed [DW-1:0] r_mem_out1   [DEPTH];
  logic signed [DW:0]   r_mem_margin [DEPTH];
  logic                 r_mem_class  [DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [AW:0]          r_level;

  // Status registers
  logic [CW-1:0]        r_drop_cnt;
  logic                 r_overflow;
  logic                 r_proto_err;

  // Combinational control
  logic                 w_cap;
  logic                 w_perr;
  logic                 w_valid;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic signed [DW:0]   w_margin_p0;
  logic                 w_class_p0;

  assign w_cap       = out0_ready & out1_ready;
  assign w_perr      = out0_ready ^ out1_ready;
  assign w_valid     = (r_level != '0);
  assign w_full      = (r_level == LVL_FULL);
  assign w_pop       = w_valid & res_ready;
  // A full FIFO can still accept a push when the head leaves this cycle.
  assign w_push      = r_vld_p0 & (~w_full | w_pop);
  assign w_drop      = r_vld_p0 & w_full & ~w_pop;
  assign w_margin_p0 = calc_margin(r_out0_p0, r_out1_p0);
  assign w_class_p0  = calc_class(w_margin_p0);

  // ---- Stage C: capture result pair on coincident ready pulses ----
  // Capture valid flag: set only when both readies pulse together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_cap;
    end
  end

  // Capture data: loaded on a valid pulse pair, otherwise held.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_out0_p0 <= out0;
      r_out1_p0 <= out1;
    end
  end

  // ---- Stage C -> FIFO: margin/class computed and written on push ----
  // FIFO storage write at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_out0[r_wptr]   <= r_out0_p0;
      r_mem_out1[r_wptr]   <= r_out1_p0;
      r_mem_margin[r_wptr] <= w_margin_p0;
      r_mem_class[r_wptr]  <= w_class_p0;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Drop counter and sticky flags; clear takes priority over new events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else if (clr) begin
      r_drop_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_drop) begin
        r_drop_cnt <= sat_inc(r_drop_cnt);
        r_overflow <= 1'b1;
      end
      if (w_perr) r_proto_err <= 1'b1;
    end
  end

  // ---- Output: head entry, zeroed whenever the FIFO is empty ----
  // Gating on the registered level keeps the unreset storage invisible
  // after reset and avoids any path from res_ready to the outputs.
  always_comb begin
    res_out0   = '0;
    res_out1   = '0;
    res_margin = '0;
    res_class  = 1'b0;
    if (w_valid) begin
      res_out0   = r_mem_out0[r_rptr];
      res_out1   = r_mem_out1[r_rptr];
      res_margin = r_mem_margin[r_rptr];
      res_class  = r_mem_class[r_rptr];
    end
  end

  assign res_valid  = w_valid;
  assign fifo_level = r_level;
  assign drop_count = r_drop_cnt;
  assign overflow   = r_overflow;
  assign proto_err  = r_proto_err;

endmodule
